// File: rtl/uart_pkg.sv
// UART shared definitions: state encoding and framing constants.
// Used by both the receive and transmit sides.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_e;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_MIN_PERIOD = 4;
  localparam int PERIOD_9600_50M = 5208;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the rx pin plus falling-edge detect.
// Flops reset high so the line looks idle out of reset.
module uart_rx_sync (
  input  logic clk,
  input  logic rstn,
  input  logic rxd,
  output logic rxd_s,
  output logic fall
);

  logic [2:0] sh;

  // shift the pin through two sync stages and keep one history bit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sh <= 3'b111;
    else       sh <= {sh[1:0], rxd};
  end

  assign rxd_s = sh[1];
  assign fall  = ~sh[1] & sh[2];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first, run-time bit period in clocks.
// Define UART_RX_PARITY_EN to add a parity bit before the stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int PERIOD_W   = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [PERIOD_W-1:0]  period,
  input  logic                 rxd,
  input  logic                 rx_clear,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_avai,
  output logic                 rx_overrun,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int IDX_W = $clog2(DATA_BITS + 1);

`ifdef UART_RX_PARITY_EN
  localparam uart_state_e AFTER_DATA = PARITY;
`else
  localparam uart_state_e AFTER_DATA = STOP;
`endif

  uart_state_e          state, state_d;
  logic [PERIOD_W-1:0]  cnt, cnt_d;
  logic [PERIOD_W-1:0]  p_lat, p_lat_d;
  logic [PERIOD_W-1:0]  p_eff, half;
  logic [IDX_W-1:0]     idx, idx_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic                 rxd_s, fall;
  logic                 cnt_hit, par_ok;
  logic                 done, ferr_d;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rstn  (rstn),
    .rxd   (rxd),
    .rxd_s (rxd_s),
    .fall  (fall)
  );

  assign p_eff = (period < PERIOD_W'(UART_MIN_PERIOD))
               ? PERIOD_W'(UART_MIN_PERIOD) : period;
  assign half    = p_lat >> 1;
  assign cnt_hit = (cnt == p_lat - 1'b1);
  assign busy    = (state != IDLE);

`ifdef UART_RX_PARITY_EN
  logic par_bit, par_d, perr_d;

  assign par_ok = (par_bit == (^shreg ^ PARITY_ODD));

  // parity bit sampled mid-bit, checked when the stop bit lands
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bit    <= par_d;
      parity_err <= perr_d;
    end
  end
`else
  logic unused_par;

  assign unused_par = PARITY_ODD;
  assign par_ok     = 1'b1;
  assign parity_err = 1'b0;
`endif

  // frame state, bit timer, bit index and shift register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      p_lat <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      p_lat <= p_lat_d;
      idx   <= idx_d;
      shreg <= shreg_d;
    end
  end

  // next-state: start qualify, mid-bit sampling, stop check
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    p_lat_d = p_lat;
    idx_d   = idx;
    shreg_d = shreg;
    done    = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d  = par_bit;
    perr_d = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (fall) begin
          p_lat_d = p_eff;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt == half - 1'b1) begin
          cnt_d = '0;
          if (rxd_s) begin
            state_d = IDLE;
          end else begin
            idx_d   = '0;
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt_hit) begin
          cnt_d   = '0;
          shreg_d = {rxd_s, shreg[DATA_BITS-1:1]};
          idx_d   = idx + 1'b1;
          if (idx == IDX_W'(DATA_BITS - 1))
            state_d = AFTER_DATA;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_hit) begin
          cnt_d   = '0;
          par_d   = rxd_s;
          state_d = STOP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt_hit) begin
          cnt_d = '0;
          if (rxd_s) begin
            state_d = IDLE;
            if (par_ok) done = 1'b1;
`ifdef UART_RX_PARITY_EN
            else perr_d = 1'b1;
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      BREAK: begin
        if (rxd_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // holding register and status; completion beats a same-cycle clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_data    <= '0;
      rx_avai    <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= ferr_d;
      if (done) begin
        rx_data <= shreg;
        rx_avai <= 1'b1;
      end else if (rx_clear) begin
        rx_avai <= 1'b0;
      end
      if (rx_clear)
        rx_overrun <= 1'b0;
      else if (done && rx_avai)
        rx_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames from a bench-side
// transmitter, expectations from a byte-level status model.
module tb_uart_rx;

  localparam bit PARITY_ODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rxd = 1'b1;
  logic        rx_clear = 1'b0;
  logic [15:0] period = 16'd16;
  logic [7:0]  rx_data;
  logic        rx_avai, rx_overrun;
  logic        frame_err, parity_err, busy;

  int n_chk = 0;
  int n_pass = 0;
  int ferr_n = 0;
  int perr_n = 0;
  int rise_n = 0;
  logic avai_q = 1'b0;

  logic [7:0] e_data = 8'h00;
  logic       e_avai = 1'b0;
  logic       e_ovr  = 1'b0;

  uart_rx dut (
    .clk        (clk),
    .rstn       (rstn),
    .period     (period),
    .rxd        (rxd),
    .rx_clear   (rx_clear),
    .rx_data    (rx_data),
    .rx_avai    (rx_avai),
    .rx_overrun (rx_overrun),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) ferr_n++;
    if (parity_err) perr_n++;
    if (rx_avai && !avai_q) rise_n++;
    avai_q = rx_avai;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_data"}, 32'(rx_data), 32'(e_data));
    chk({tag, "_avai"}, 32'(rx_avai), 32'(e_avai));
    chk({tag, "_ovr"}, 32'(rx_overrun), 32'(e_ovr));
  endtask

  task automatic model_good(input logic [7:0] b, input bit clr_same);
    if (clr_same) e_ovr = 1'b0;
    else if (e_avai) e_ovr = 1'b1;
    e_avai = 1'b1;
    e_data = b;
  endtask

  task automatic clear();
    rx_clear = 1'b1;
    @(negedge clk);
    rx_clear = 1'b0;
    e_avai = 1'b0;
    e_ovr  = 1'b0;
  endtask

  // one frame on the pin; period input is scrambled mid-frame
  task automatic send(input logic [7:0] b, input bit stop_ok,
                      input bit par_flip, input int abort_bit);
    int p;
    logic [15:0] keep;
    p = (period < 16'd4) ? 4 : int'(period);
    keep = period;
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    period = 16'($urandom);
    repeat (p - 4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      if (i == abort_bit) begin
        repeat (p / 2) @(negedge clk);
        period = keep;
        return;
      end
      repeat (p) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rxd = ^b ^ PARITY_ODD ^ par_flip;
    repeat (p) @(negedge clk);
`else
    if (par_flip) rxd = 1'b1;
`endif
    rxd = stop_ok;
    repeat (p) @(negedge clk);
    period = keep;
  endtask

  task automatic frame_ok(input string tag, input logic [7:0] b);
    int r0, f0, er;
    r0 = rise_n;
    f0 = ferr_n;
    er = e_avai ? 0 : 1;
    send(b, 1'b1, 1'b0, -1);
    idle(4);
    model_good(b, 1'b0);
    chk({tag, "_rise"}, 32'(rise_n - r0), 32'(er));
    chk({tag, "_ferr"}, 32'(ferr_n - f0), 32'd0);
    check_status(tag);
  endtask

  initial begin
    int f0, p0, k;
    logic [7:0] b;

    idle(2);
    chk("rst_data", 32'(rx_data), 32'd0);
    chk("rst_avai", 32'(rx_avai), 32'd0);
    chk("rst_ovr", 32'(rx_overrun), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_perr", 32'(parity_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rstn = 1'b1;
    idle(4);

    period = 16'd5208;
    frame_ok("b2b_5208", 8'hB5);
    clear();
    period = 16'd16;
    frame_ok("b2b_00", 8'h00);
    clear();
    frame_ok("b2b_ff", 8'hFF);
    clear();
    frame_ok("b2b_5a", 8'h5A);
    clear();
    check_status("clr");

    f0 = ferr_n;
    rxd = 1'b0;
    idle(3);
    rxd = 1'b1;
    idle(10);
    chk("glitch_busy", 32'(busy), 32'd0);
    chk("glitch_ferr", 32'(ferr_n - f0), 32'd0);
    check_status("glitch");

    f0 = ferr_n;
    send(8'h3C, 1'b0, 1'b0, -1);
    idle(32);
    chk("brk_ferr", 32'(ferr_n - f0), 32'd1);
    chk("brk_busy", 32'(busy), 32'd1);
    check_status("brk");
    rxd = 1'b1;
    idle(6);
    chk("brk_idle", 32'(busy), 32'd0);
    frame_ok("after_brk", 8'h81);
    clear();

`ifdef UART_RX_PARITY_EN
    p0 = perr_n;
    send(8'hB5, 1'b1, 1'b1, -1);
    idle(4);
    chk("par_bad_perr", 32'(perr_n - p0), 32'd1);
    check_status("par_bad");
    frame_ok("par_good", 8'hB5);
    clear();
`else
    p0 = perr_n;
    frame_ok("noparity", 8'hC3);
    chk("noparity_perr", 32'(perr_n - p0), 32'd0);
    clear();
`endif

    frame_ok("ovr_11", 8'h11);
    frame_ok("ovr_22", 8'h22);
    k = 2 + 8 + (9 + NPAR) * 16;
    fork
      send(8'h33, 1'b1, 1'b0, -1);
      begin
        repeat (k) @(negedge clk);
        rx_clear = 1'b1;
        @(negedge clk);
        rx_clear = 1'b0;
      end
    join
    idle(4);
    model_good(8'h33, 1'b1);
    check_status("race");

    send(8'h5C, 1'b1, 1'b0, 4);
    rstn = 1'b0;
    #1;
    e_data = 8'h00;
    e_avai = 1'b0;
    e_ovr  = 1'b0;
    check_status("midrst");
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ferr", 32'(frame_err), 32'd0);
    chk("midrst_perr", 32'(parity_err), 32'd0);
    rxd = 1'b1;
    idle(3);
    rstn = 1'b1;
    idle(4);
    frame_ok("post_rst", 8'hA7);

    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 1) clear();
      period = 16'($urandom_range(0, 24));
      b = 8'($urandom);
      frame_ok($sformatf("rnd%0d", i), b);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
